// File: rtl/fpu_issue_scheduler.sv
// Issue controller for the pipelined FPU model: valid/ready issue with a RAW/WAW busy
// scoreboard, an ID/rd shift register mirroring the model, and a back-pressured result port.
module fpu_issue_scheduler #(
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned PIPELINE_STAGES = 4,
  parameter int unsigned X_ID_WIDTH      = 4,
  localparam int unsigned RW = $clog2(NUM_REGS),
  localparam int unsigned CW = $clog2(PIPELINE_STAGES + 1)
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  input  logic [RW-1:0]         issue_rs1,
  input  logic [RW-1:0]         issue_rs2,
  input  logic [RW-1:0]         issue_rs3,
  input  logic [2:0]            issue_rs_used,
  input  logic [RW-1:0]         issue_rd,
  input  logic                  issue_wr_fpr,
  output logic                  fpu_enable,
  output logic [X_ID_WIDTH-1:0] fpu_id,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [X_ID_WIDTH-1:0] res_id,
  output logic [RW-1:0]         res_rd,
  output logic                  res_wr_fpr,
  output logic [CW-1:0]         inflight,
  output logic [NUM_REGS-1:0]   sb_busy
);

  // Position 0 captures the accepted instruction; positions 1..PIPELINE_STAGES track the
  // model, so res_valid rises PIPELINE_STAGES edges after the accept edge.
  localparam int unsigned LAST = PIPELINE_STAGES;

  logic [LAST:0]         v_q, v_d;
  logic [LAST:0]         wr_q, wr_d;
  logic [X_ID_WIDTH-1:0] id_q [LAST+1];
  logic [X_ID_WIDTH-1:0] id_d [LAST+1];
  logic [RW-1:0]         rd_q [LAST+1];
  logic [RW-1:0]         rd_d [LAST+1];
  logic [NUM_REGS-1:0]   sb_q, sb_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  stall, hazard, accept, res_hs;

  assign res_valid  = v_q[LAST];
  assign res_id     = id_q[LAST];
  assign res_rd     = rd_q[LAST];
  assign res_wr_fpr = wr_q[LAST];
  assign sb_busy    = sb_q;
  assign inflight   = inflight_q;
  assign fpu_id     = issue_id;
  assign fpu_enable = accept;

  always_comb begin
    stall  = v_q[LAST] & ~res_ready;
    res_hs = v_q[LAST] & res_ready;
    hazard = (issue_rs_used[0] & sb_q[issue_rs1])
           | (issue_rs_used[1] & sb_q[issue_rs2])
           | (issue_rs_used[2] & sb_q[issue_rs3])
           | (issue_wr_fpr & sb_q[issue_rd]);
    issue_ready = ~rst & ~flush & ~stall & ~hazard;
    accept      = issue_valid & issue_ready;
  end

  always_comb begin
    v_d  = v_q;
    wr_d = wr_q;
    id_d = id_q;
    rd_d = rd_q;
    if (!stall) begin
      v_d[0]  = accept;
      wr_d[0] = issue_wr_fpr;
      id_d[0] = issue_id;
      rd_d[0] = issue_rd;
      for (int unsigned i = 1; i <= LAST; i++) begin
        v_d[i]  = v_q[i-1];
        wr_d[i] = wr_q[i-1];
        id_d[i] = id_q[i-1];
        rd_d[i] = rd_q[i-1];
      end
    end
    if (flush) v_d = '0;
  end

  always_comb begin
    sb_d = sb_q;
    if (res_hs && wr_q[LAST]) sb_d[rd_q[LAST]] = 1'b0;
    if (accept && issue_wr_fpr) sb_d[issue_rd] = 1'b1;
    if (flush) sb_d = '0;

    inflight_d = inflight_q;
    if (accept && !res_hs)      inflight_d = inflight_q + CW'(1);
    else if (!accept && res_hs) inflight_d = inflight_q - CW'(1);
    if (flush) inflight_d = '0;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      v_q        <= '0;
      wr_q       <= '0;
      sb_q       <= '0;
      inflight_q <= '0;
      for (int unsigned i = 0; i <= LAST; i++) begin
        id_q[i] <= '0;
        rd_q[i] <= '0;
      end
    end else begin
      v_q        <= v_d;
      wr_q       <= wr_d;
      id_q       <= id_d;
      rd_q       <= rd_d;
      sb_q       <= sb_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Scoreboard bench for fpu_issue_scheduler: accepted instructions are queued with their due
// time; the negedge monitor compares every cycle against that behavioural model.
module tb_fpu_issue_scheduler;
  localparam int P   = 4;
  localparam int NR  = 32;
  localparam int IDW = 4;
  localparam int RW  = 5;
  localparam int CW  = 3;

  logic           ck = 1'b0;
  logic           rst, flush, issue_valid, issue_ready, issue_wr_fpr;
  logic [IDW-1:0] issue_id, fpu_id, res_id;
  logic [RW-1:0]  issue_rs1, issue_rs2, issue_rs3, issue_rd, res_rd;
  logic [2:0]     issue_rs_used;
  logic           fpu_enable, res_valid, res_ready, res_wr_fpr;
  logic [CW-1:0]  inflight;
  logic [NR-1:0]  sb_busy;

  fpu_issue_scheduler #(.NUM_REGS(NR), .PIPELINE_STAGES(P), .X_ID_WIDTH(IDW)) dut (
    .ck(ck), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
    .issue_rs_used(issue_rs_used), .issue_rd(issue_rd), .issue_wr_fpr(issue_wr_fpr),
    .fpu_enable(fpu_enable), .fpu_id(fpu_id),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_rd(res_rd),
    .res_wr_fpr(res_wr_fpr), .inflight(inflight), .sb_busy(sb_busy)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [IDW-1:0] id;
    logic [RW-1:0]  rd;
    logic           wr;
    int unsigned    due;
  } ent_t;

  ent_t          mq[$];
  logic [NR-1:0] m_busy;
  int unsigned   tick;
  bit            started  = 0;
  bit            prev_rst = 0;
  int            vectors     = 0;
  int            miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic exp_stall, exp_hazard, exp_ready, exp_rv, acc, hs;

  always @(negedge ck) begin
    exp_rv     = (mq.size() > 0) && (mq[0].due == tick);
    exp_stall  = exp_rv && !res_ready;
    exp_hazard = (issue_rs_used[0] && m_busy[issue_rs1]) ||
                 (issue_rs_used[1] && m_busy[issue_rs2]) ||
                 (issue_rs_used[2] && m_busy[issue_rs3]) ||
                 (issue_wr_fpr && m_busy[issue_rd]);
    exp_ready  = !rst && !flush && !exp_stall && !exp_hazard;
    acc        = issue_valid && exp_ready;
    hs         = exp_rv && res_ready;

    if (started) begin
      chk("issue_ready", 64'(issue_ready), 64'(exp_ready));
      chk("fpu_enable", 64'(fpu_enable), 64'(acc));
      if (fpu_enable) chk("fpu_id", 64'(fpu_id), 64'(issue_id));
      chk("res_valid", 64'(res_valid), 64'(exp_rv));
      chk("inflight", 64'(inflight), 64'(mq.size()));
      chk("sb_busy", 64'(sb_busy), 64'(m_busy));
      if (exp_rv) begin
        chk("res_id", 64'(res_id), 64'(mq[0].id));
        chk("res_rd", 64'(res_rd), 64'(mq[0].rd));
        chk("res_wr_fpr", 64'(res_wr_fpr), 64'(mq[0].wr));
      end
      if (prev_rst) chk("reset_res_fields", {res_id, res_rd, res_wr_fpr}, '0);
    end

    // advance the model to the state expected after the coming rising edge
    if (rst) begin
      mq.delete();
      m_busy  = '0;
      tick    = 0;
      started = 1;
    end else if (started) begin
      if (hs) begin
        if (mq[0].wr) m_busy[mq[0].rd] = 1'b0;
        void'(mq.pop_front());
      end
      if (flush) begin
        mq.delete();
        m_busy = '0;
      end else if (acc) begin
        mq.push_back('{id: issue_id, rd: issue_rd, wr: issue_wr_fpr, due: tick + P + 1});
        if (issue_wr_fpr) m_busy[issue_rd] = 1'b1;
      end
      if (!exp_stall) tick++;
    end
    prev_rst = rst;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic do_issue(input logic [IDW-1:0] id, input logic [RW-1:0] rs1,
                          input logic [RW-1:0] rs2, input logic [RW-1:0] rs3,
                          input logic [2:0] used, input logic [RW-1:0] rd, input logic wr);
    bit done = 0;
    issue_id = id; issue_rs1 = rs1; issue_rs2 = rs2; issue_rs3 = rs3;
    issue_rs_used = used; issue_rd = rd; issue_wr_fpr = wr; issue_valid = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge ck);
      done = issue_ready;
      @(posedge ck);
      #1;
    end
    issue_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: id %0h not accepted, expected acceptance", id);
    end
  endtask

  task automatic wait_res_valid();
    bit seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge ck);
      seen = res_valid;
    end
    @(posedge ck);
    #1;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL res_valid_timeout: got 0, expected 1");
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
    issue_valid = 1'b1; issue_id = '0; issue_rs1 = '0; issue_rs2 = '0; issue_rs3 = '0;
    issue_rs_used = '0; issue_rd = '0; issue_wr_fpr = 1'b0;
    cyc(2);
    issue_valid = 1'b0;
    rst = 1'b0;

    // latency: id 3 -> rd 5
    do_issue(4'd3, '0, '0, '0, 3'b000, 5'd5, 1'b1);
    cyc(8);

    // RAW on register 7
    do_issue(4'd1, '0, '0, '0, 3'b000, 5'd7, 1'b1);
    do_issue(4'd2, 5'd7, '0, '0, 3'b001, 5'd8, 1'b1);
    cyc(8);

    // back-pressure with ids 0..3
    for (int i = 0; i < 4; i++)
      do_issue(IDW'(i), '0, '0, '0, 3'b000, RW'(10 + i), 1'b1);
    res_ready = 1'b0;
    wait_res_valid();
    cyc(2);
    res_ready = 1'b1;
    cyc(8);

    // flush with rds 1, 2, 3 in flight
    for (int i = 1; i <= 3; i++)
      do_issue(IDW'(4 + i), '0, '0, '0, 3'b000, RW'(i), 1'b1);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(8);

    // unused rs2 names a busy register
    do_issue(4'd9, '0, '0, '0, 3'b000, 5'd9, 1'b1);
    do_issue(4'd10, 5'd0, 5'd9, '0, 3'b001, 5'd11, 1'b1);
    cyc(8);

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      issue_valid   = ($urandom_range(99) < 70);
      issue_id      = IDW'($urandom);
      issue_rs1     = RW'($urandom_range(7));
      issue_rs2     = RW'($urandom_range(7));
      issue_rs3     = RW'($urandom_range(7));
      issue_rs_used = 3'($urandom);
      issue_rd      = RW'($urandom_range(7));
      issue_wr_fpr  = ($urandom_range(99) < 75);
      res_ready     = ($urandom_range(99) < 70);
      flush         = ($urandom_range(99) < 2);
      rst           = ($urandom_range(199) < 1);
      cyc(1);
    end
    issue_valid = 1'b0; flush = 1'b0; rst = 1'b0; res_ready = 1'b1;
    cyc(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
